// File: rtl/mimi_loader_pkg.sv
// Shared types and constants for the mimi program-RAM loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mimi_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RMW_RD,
    S_RMW_WR,
    S_ACK
  } state_t;

  localparam logic [15:0] OFF_CTRL   = 16'h0000;
  localparam logic [15:0] OFF_STATUS = 16'h0004;
  localparam logic [15:0] OFF_CRC    = 16'h0008;

  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

  // Bit-reverse a word; used to derive the reflected polynomial.
  function automatic logic [31:0] bit_reverse32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // Replace the bytes of old_w selected by sel with the bytes of new_w.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  sel);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/mimi_crc32_word.sv
// Reflected CRC-32 next-state for one 32-bit word, low byte first.
// Latency: combinational.
// Backpressure: none.
module mimi_crc32_word
  import mimi_loader_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [31:0] data,
  output logic [31:0] crc_out
);

  localparam logic [31:0] POLY_R = bit_reverse32(CRC_POLY);

  // Thirty-two LSB-first shift/xor steps over the word.
  always_comb begin
    crc_out = crc_in ^ data;
    for (int i = 0; i < 32; i++) begin
      crc_out = crc_out[0] ? ((crc_out >> 1) ^ POLY_R) : (crc_out >> 1);
    end
  end

endmodule

// File: rtl/mimi_wb_loader.sv
// Wishbone slave loading/inspecting the mimi program RAM and driving cpu run/reset.
// Latency stb->ack: register 1, full write 1, read 2, partial write (RMW) 3 cycles.
// Backpressure: one access at a time; a new request is taken the cycle after ack.
// Build option: MIMI_LOADER_CRC_EN adds a CRC-32 over committed RAM word writes.
module mimi_wb_loader #(
  parameter logic [15:0] BASE_HI    = 16'h3000,
  parameter int unsigned RAM_AW     = 11,
  parameter logic [15:0] RAM_OFFSET = 16'h2000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic              mem_req,
  output logic              mem_we,
  output logic [RAM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              cpu_reset
);
  import mimi_loader_pkg::*;

  localparam int unsigned RAM_BYTES = 4 << RAM_AW;
  localparam logic [16:0] RAM_END   = {1'b0, RAM_OFFSET} + 17'(RAM_BYTES);

  state_t            state_q, state_d;
  logic [RAM_AW-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        sel_q;
  logic              abort_q;
  logic [31:0]       dat_q;
  logic              run_q;
  logic              cpu_reset_q;
  logic              drop_q;
  logic [31:0]       reg_rdata;
  logic [31:0]       crc_view;

  logic [15:0] off;
  logic        hit, is_ram, is_ctrl, is_status, is_crc, take;

  assign off       = wbs_adr_i[15:0];
  assign hit       = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:16] == BASE_HI);
  assign is_ram    = ({1'b0, off} >= {1'b0, RAM_OFFSET}) && ({1'b0, off} < RAM_END);
  assign is_ctrl   = (off == OFF_CTRL);
  assign is_status = (off == OFF_STATUS);
  assign is_crc    = (off == OFF_CRC);
  assign take      = (state_q == S_IDLE) && hit;

  assign wbs_dat_o = dat_q;
  assign cpu_reset = cpu_reset_q;

`ifdef MIMI_LOADER_CRC_EN
  logic [31:0] crc_q, crc_next;
  logic        crc_clear;

  mimi_crc32_word u_crc (
    .crc_in  (crc_q),
    .data    (mem_wdata),
    .crc_out (crc_next)
  );

  // Reinit on a write to the CRC register or on a run 0->1 edge.
  assign crc_clear = take && wbs_we_i &&
                     (is_crc || (is_ctrl && wbs_sel_i[0] && wbs_dat_i[0] && !run_q));
  assign crc_view  = ~crc_q;

  // CRC accumulates every word actually written to the SRAM.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)              crc_q <= CRC_INIT;
    else if (crc_clear)        crc_q <= CRC_INIT;
    else if (mem_req && mem_we) crc_q <= crc_next;
  end
`else
  assign crc_view = '0;
`endif

  // Register read mux; unmapped offsets read as zero.
  always_comb begin
    reg_rdata = '0;
    if (is_ctrl)        reg_rdata = {31'b0, run_q};
    else if (is_status) reg_rdata = {30'b0, drop_q, ~cpu_reset_q};
    else if (is_crc)    reg_rdata = crc_view;
  end

  // Next-state and SRAM/ack outputs; reset squashes any request or ack in flight.
  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    wbs_ack_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        mem_addr  = wbs_adr_i[RAM_AW+1:2];
        mem_wdata = wbs_dat_i;
        if (hit) begin
          state_d = S_ACK;
          if (is_ram && cpu_reset_q) begin
            if (!wbs_we_i) begin
              mem_req = 1'b1;
              state_d = S_RD;
            end else if (wbs_sel_i == 4'hF) begin
              mem_req = 1'b1;
              mem_we  = 1'b1;
            end else if (wbs_sel_i != 4'h0) begin
              state_d = S_RMW_RD;
            end
          end
        end
      end
      S_RD:     state_d = S_ACK;
      S_RMW_RD: begin
        mem_req = 1'b1;
        state_d = S_RMW_WR;
      end
      S_RMW_WR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_wdata = merge_bytes(mem_rdata, wdata_q, sel_q);
        state_d   = S_ACK;
      end
      S_ACK: begin
        wbs_ack_o = !abort_q && wbs_cyc_i;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (wb_rst_i) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      wbs_ack_o = 1'b0;
      state_d   = S_IDLE;
    end
  end

  // FSM state register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Request capture, register file, read data and cyc-abort tracking.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      sel_q       <= '0;
      abort_q     <= 1'b0;
      dat_q       <= '0;
      run_q       <= 1'b0;
      cpu_reset_q <= 1'b1;
      drop_q      <= 1'b0;
    end else begin
      cpu_reset_q <= ~run_q;
      if (take) begin
        addr_q  <= wbs_adr_i[RAM_AW+1:2];
        wdata_q <= wbs_dat_i;
        sel_q   <= wbs_sel_i;
        abort_q <= 1'b0;
        if (!is_ram) begin
          dat_q <= reg_rdata;
        end else if (!cpu_reset_q) begin
          dat_q  <= '0;
          drop_q <= 1'b1;
        end
        if (wbs_we_i && is_ctrl && wbs_sel_i[0]) run_q <= wbs_dat_i[0];
        if (wbs_we_i && is_status && wbs_sel_i[0] && wbs_dat_i[1]) drop_q <= 1'b0;
      end else if (state_q != S_IDLE && !wbs_cyc_i) begin
        abort_q <= 1'b1;
      end
      if (state_q == S_RD) dat_q <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mimi_wb_loader.sv
// Self-checking bench for mimi_wb_loader against a behavioural RAM/register/CRC model.
// Latency: checks stb->ack cycle counts for every access class.
// Backpressure: one bus access at a time, every wait bounded.
module tb_mimi_wb_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, dat_w = '0;
  logic        ack;
  logic [31:0] dat_r;
  logic        mem_req, mem_we;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        cpu_reset;

  int checks = 0;
  int errors = 0;

  logic [31:0] sram [0:2047];
  int we_cnt = 0, ack_cnt = 0, bad_req = 0;
  logic [10:0] last_we_addr = '0;

  // Behavioural model state
  logic [31:0] model_ram [0:2047];
  bit          model_run;
  bit          model_drop;
  logic [31:0] model_crc;

  mimi_wb_loader dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (dat_w),
    .wbs_ack_o (ack),
    .wbs_dat_o (dat_r),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .cpu_reset (cpu_reset)
  );

  always #5 clk = ~clk;

  // SRAM model with one-cycle read latency, plus bus event counters.
  always @(posedge clk) begin
    if (mem_req && !mem_we) mem_rdata <= sram[mem_addr];
    if (mem_req && mem_we) begin
      sram[mem_addr] <= mem_wdata;
      we_cnt++;
      last_we_addr = mem_addr;
    end
    if (mem_req && !cpu_reset) bad_req++;
    if (ack) ack_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_model_word(input logic [31:0] c, input logic [31:0] w);
    logic [31:0] r;
    r = c;
    for (int b = 0; b < 4; b++) begin
      r = r ^ {24'h0, w[8*b +: 8]};
      for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic [31:0] apply_sel(input logic [31:0] o, input logic [31:0] n,
                                            input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (o & ~m) | (n & m);
  endfunction

  // One Wishbone access; lat = cycles from stb to ack, -1 if no ack within budget.
  task automatic wb_xfer(input bit w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, output logic [31:0] rd, output int lat);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; dat_w = d;
    lat = -1;
    rd  = '0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (ack) begin
        lat = c;
        rd  = dat_r;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  // RAM access checked against the model.
  task automatic ram_op(input string tag, input bit w, input int idx,
                        input logic [3:0] s, input logic [31:0] d);
    logic [31:0] rd, exp_rd, merged;
    int lat, exp_lat;
    exp_rd = '0;
    if (model_run) begin
      exp_lat    = 1;
      model_drop = 1'b1;
    end else if (!w) begin
      exp_lat = 2;
      exp_rd  = model_ram[idx];
    end else if (s == 4'hF || s == 4'h0) begin
      exp_lat = 1;
    end else begin
      exp_lat = 3;
    end
    wb_xfer(w, 32'h3000_2000 + 32'(idx) * 4, s, d, rd, lat);
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    if (!w) check_eq({tag, "_data"}, rd, exp_rd);
    if (w && !model_run && s != 4'h0) begin
      merged         = apply_sel(model_ram[idx], d, s);
      model_ram[idx] = merged;
      model_crc      = crc_model_word(model_crc, merged);
    end
  endtask

  // Register access checked against the model.
  task automatic reg_op(input string tag, input bit w, input logic [15:0] o,
                        input logic [31:0] d);
    logic [31:0] rd, exp_rd;
    int lat;
    exp_rd = '0;
    if (o == 16'h0000) exp_rd = {31'b0, model_run};
    if (o == 16'h0004) exp_rd = {30'b0, model_drop, model_run};
`ifdef MIMI_LOADER_CRC_EN
    if (o == 16'h0008) exp_rd = ~model_crc;
`endif
    wb_xfer(w, {16'h3000, o}, 4'hF, d, rd, lat);
    check_eq({tag, "_lat"}, 32'(lat), 32'd1);
    if (!w) check_eq({tag, "_data"}, rd, exp_rd);
    if (w) begin
      if (o == 16'h0000) begin
        if (d[0] && !model_run) model_crc = 32'hFFFFFFFF;
        model_run = d[0];
      end
      if (o == 16'h0004 && d[1]) model_drop = 1'b0;
`ifdef MIMI_LOADER_CRC_EN
      if (o == 16'h0008) model_crc = 32'hFFFFFFFF;
`endif
    end
  endtask

  task automatic model_reset();
    model_run  = 1'b0;
    model_drop = 1'b0;
    model_crc  = 32'hFFFFFFFF;
  endtask

  initial begin
    logic [31:0] rd;
    int lat, we0, ack0, idx;
    logic [3:0] s;

    for (int i = 0; i < 2048; i++) begin
      sram[i]      = '0;
      model_ram[i] = '0;
    end
    model_reset();

    // 1: reset values, then STATUS read
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ack", {31'b0, ack}, 32'd0);
    check_eq("rst_dat", dat_r, 32'd0);
    check_eq("rst_req", {30'b0, mem_req, mem_we}, 32'd0);
    check_eq("rst_cpu_reset", {31'b0, cpu_reset}, 32'd1);
    rst = 1'b0;
    reg_op("status0", 1'b0, 16'h0004, '0);
    reg_op("ctrl0", 1'b0, 16'h0000, '0);

    // 2: full write then read back
    we0 = we_cnt;
    ram_op("wr_full", 1'b1, 0, 4'hF, 32'hDEADBEEF);
    check_eq("wr_full_pulses", 32'(we_cnt - we0), 32'd1);
    check_eq("wr_full_addr", {21'b0, last_we_addr}, 32'd0);
    ram_op("rd_full", 1'b0, 0, 4'hF, '0);
    check_eq("rd_full_const", rd_const(0), 32'hDEADBEEF);

    // 3: partial write via RMW, sel==0 write, window edges, unmapped offsets
    ram_op("wr_w1", 1'b1, 1, 4'hF, 32'h11223344);
    ram_op("wr_rmw", 1'b1, 1, 4'b0010, 32'h0000AA00);
    ram_op("rd_rmw", 1'b0, 1, 4'hF, '0);
    check_eq("rmw_const", rd_const(1), 32'h1122AA44);
    we0 = we_cnt;
    ram_op("wr_sel0", 1'b1, 1, 4'h0, 32'hFFFFFFFF);
    check_eq("sel0_no_we", 32'(we_cnt - we0), 32'd0);
    ram_op("wr_last", 1'b1, 2047, 4'hF, 32'hCAFEF00D);
    ram_op("rd_last", 1'b0, 2047, 4'hF, '0);
    reg_op("unmapped", 1'b0, 16'h0010, '0);
    reg_op("below_win", 1'b0, 16'h1FFC, '0);
    reg_op("above_win", 1'b0, 16'h4000, '0);
    reg_op("crc_rd0", 1'b0, 16'h0008, '0);
    wb_xfer(1'b0, 32'h4000_2000, 4'hF, '0, rd, lat);
    check_eq("nonhit_noack", 32'(lat), 32'hFFFF_FFFF);

    // randomized RAM traffic while the core is held in reset
    for (int n = 0; n < 80; n++) begin
      idx = ($urandom_range(0, 9) == 0) ? 2047 : int'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       s = 4'hF;
        1:       s = 4'h0;
        default: s = 4'($urandom_range(1, 14));
      endcase
      ram_op("rnd", 1'($urandom_range(0, 1)), idx, s, $urandom());
    end
    reg_op("crc_rnd", 1'b0, 16'h0008, '0);

    // cyc dropped mid-access: no ack, but the RMW write still completes
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'b1000; adr = 32'h3000_200C; dat_w = 32'h5A000000;
    @(posedge clk); #1;
    ack0 = ack_cnt;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("cycdrop_noack", 32'(ack_cnt - ack0), 32'd0);
    model_ram[3] = apply_sel(model_ram[3], 32'h5A000000, 4'b1000);
    model_crc    = crc_model_word(model_crc, model_ram[3]);
    ram_op("cycdrop_rd", 1'b0, 3, 4'hF, '0);

    // 4: run the core; RAM hits are dropped and flagged
    reg_op("ctrl_run", 1'b1, 16'h0000, 32'h1);
    check_eq("cpu_reset_at_ack", {31'b0, cpu_reset}, 32'd1);
    @(posedge clk); #1;
    check_eq("cpu_reset_after_ack", {31'b0, cpu_reset}, 32'd0);
    we0 = we_cnt;
    ram_op("drop_wr", 1'b1, 0, 4'hF, 32'h12345678);
    ram_op("drop_rd", 1'b0, 0, 4'hF, '0);
    check_eq("drop_no_we", 32'(we_cnt - we0), 32'd0);
    reg_op("status_run", 1'b0, 16'h0004, '0);
    check_eq("status_run_const", {30'b0, model_drop, model_run}, 32'h3);
    reg_op("status_clr", 1'b1, 16'h0004, 32'h2);
    reg_op("status_clred", 1'b0, 16'h0004, '0);
    reg_op("ctrl_stop", 1'b1, 16'h0000, 32'h0);
    ram_op("rd_after_stop", 1'b0, 0, 4'hF, '0);

    // 5: reset asserted while the RMW read is in flight
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'b0100; adr = 32'h3000_2008; dat_w = 32'h00770000;
    @(posedge clk); #1;
    we0  = we_cnt;
    ack0 = ack_cnt;
    rst  = 1'b1;
    cyc  = 1'b0; stb = 1'b0; we = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rstmid_noack", 32'(ack_cnt - ack0), 32'd0);
    check_eq("rstmid_no_we", 32'(we_cnt - we0), 32'd0);
    check_eq("rstmid_cpu_reset", {31'b0, cpu_reset}, 32'd1);
    rst = 1'b0;
    model_reset();
    ram_op("rstmid_rd", 1'b0, 2, 4'hF, '0);

    // 6: CRC of one zero word after reinit
    reg_op("crc_init", 1'b1, 16'h0008, '0);
    ram_op("crc_wr0", 1'b1, 0, 4'hF, 32'h0);
    reg_op("crc_rd", 1'b0, 16'h0008, '0);
`ifdef MIMI_LOADER_CRC_EN
    check_eq("crc_zero_word", ~model_crc, 32'h2144DF1C);
`endif

    check_eq("no_req_while_running", 32'(bad_req), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  function automatic logic [31:0] rd_const(input int idx);
    return model_ram[idx];
  endfunction

endmodule
